sc_stream_decoder: RTL and testbench
====================================

Name: sc_stream_decoder

Overview:
- Receive-side converter for stochastic bitstreams: the stochastic-to-binary end of the adder-chain datapath.
- Counts 1s in a single bitstream over a fixed window of 2^WIDTH valid samples, then presents the count as a binary value.
- Sits after a stochastic adder or multiplier tree and hands the binary result to downstream logic through a start/busy/done handshake.

Parameters:
- WIDTH, 8, log2 of the window length; the window is 2^WIDTH valid samples.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a new conversion window; sampled only in IDLE or DONE.
- bit_in  input  1  stochastic bitstream sample.
- bit_valid  input  1  bit_in is valid this cycle; invalid cycles are not counted.
- busy  output  1  high while a window is being accumulated.
- done  output  1  one-cycle pulse when value updates.
- value  output  WIDTH+2  conversion result; zero-extended count (unipolar) or two's-complement (bipolar).

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, busy=0, done=0, value=0, ones accumulator=0, sample counter=0.
- States:
  - IDLE -> ACCUM on start=1; the accumulator and sample counter are cleared that cycle.
  - ACCUM: on each cycle with bit_valid=1, the accumulator increments by bit_in and the sample counter increments.
  - ACCUM -> DONE on the valid sample where sample counter == 2^WIDTH-1; value latches the final count including that sample.
  - DONE lasts one cycle with done=1, then goes to IDLE.
  - start=1 during DONE goes directly to ACCUM (back-to-back windows, no gap cycle).
- busy=1 exactly in ACCUM.
- Latency: done asserts one cycle after the clock edge that samples the last valid bit.
- Accumulator width is WIDTH+1, so an all-ones window gives 2^WIDTH with no overflow.
- Unipolar value = ones count, range 0..2^WIDTH.
- start while in ACCUM is ignored; the current window is not restarted.
- bit_valid=0 for any number of cycles stalls the window. There is no timeout.
- value holds its last result until the next completed window; it is never cleared by start.
- bit_in is ignored outside ACCUM.
- Reset asserted mid-window aborts the window; all outputs return to their reset values immediately.

Optional Feature:
- Macro: SC_DECODER_BIPOLAR_EN.
- Defined: value = 2*ones - 2^WIDTH, signed two's-complement, range -2^WIDTH..+2^WIDTH. This matches bipolar stochastic encoding.
- Undefined: unipolar count, zero-extended into WIDTH+2 bits.
- Port width and handshake timing are identical in both builds.

Decomposition:
- Shared package sc_decoder_pkg:
  - state enum {IDLE, ACCUM, DONE}.
  - helper constant WINDOW_LEN = 2^WIDTH, expressed as a function of WIDTH.
- Sub-module sc_window_counter: WIDTH-bit sample counter with clear, enable (bit_valid) and a terminal-count flag.
- Top level: the FSM, ones accumulator and output register.

Test Plan (WIDTH=4, window of 16 samples):
- Reset, then start pulse, then 16 valid cycles of bit_in=1 -> done pulses 1 cycle after the 16th sample; value=16 (bipolar: +16); busy low the same cycle done rises.
- Start, then 16 valid alternating 1/0 -> value=8 (bipolar: 0); 16 valid zeros -> value=0 (bipolar: -16).
- Start, 10 valid 1s, 5 cycles with bit_valid=0 and bit_in=1, 6 valid 0s -> value=10; done exactly 1 cycle after the 16th valid sample.
- Second start pulse at sample 7 of an active window -> ignored; done after 16 valid samples and value reflects only that window.
- start held high through DONE -> new window begins with no IDLE cycle; previous value stays stable until the second done.
- rst low at sample 9 -> busy=0, done=0, value=0 asynchronously. After release, a fresh start with 16 ones -> value=16.

Source files
------------

// File: rtl/sc_decoder_pkg.sv
// Shared types and constants for the stochastic-to-binary stream decoder.
package sc_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Window length in samples for a given log2 size.
    function automatic int window_len(input int width);
        return 1 << width;
    endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Sample counter for one conversion window; flags the last valid sample.
module sc_window_counter
    import sc_decoder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [WIDTH-1:0] LAST_SAMPLE = WIDTH'(window_len(WIDTH) - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Terminal count only fires on the valid sample that completes the window.
    assign tc_o = en_i && (count_q == LAST_SAMPLE);

endmodule

// File: rtl/sc_stream_decoder.sv
// Counts ones in a 2^WIDTH-sample stochastic window and presents the result.
// Define SC_DECODER_BIPOLAR_EN to report 2*ones - 2^WIDTH instead of the raw count.
module sc_stream_decoder
    import sc_decoder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH+1:0] value
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH:0]   ones_q;
    logic [WIDTH:0]   ones_d;
    logic [WIDTH:0]   ones_next;
    logic [WIDTH+1:0] value_q;
    logic [WIDTH+1:0] value_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;

`ifdef SC_DECODER_BIPOLAR_EN
    localparam logic [WIDTH+1:0] WIN_EXT = (WIDTH+2)'(window_len(WIDTH));
`endif

    sc_window_counter #(
        .WIDTH (WIDTH)
    ) u_window_counter (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    assign ones_next = ones_q + {{WIDTH{1'b0}}, bit_in};

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        value_d = value_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = ACCUM;
                    ones_d  = '0;
                    cnt_clr = 1'b1;
                end
            end
            ACCUM: begin
                if (bit_valid) begin
                    ones_d = ones_next;
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        state_d = DONE;
`ifdef SC_DECODER_BIPOLAR_EN
                        // Modulo subtraction yields the two's-complement result directly.
                        value_d = {ones_next, 1'b0} - WIN_EXT;
`else
                        value_d = {1'b0, ones_next};
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ones_q  <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            value_q <= value_d;
        end
    end

    assign busy  = (state_q == ACCUM);
    assign done  = (state_q == DONE);
    assign value = value_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Randomised bench for sc_stream_decoder with WIDTH=4 (16-sample windows).
module tb_sc_stream_decoder;

    localparam int W = 4;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         bit_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic         busy;
    logic         done;
    logic [W+1:0] value;

    int           n_cmp = 0;
    int           n_fail = 0;
    logic [W+1:0] last_value = '0;

    sc_stream_decoder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done),
        .value     (value)
    );

    always #5 clk = ~clk;

    // Expected result from the window's sample bits.
    function automatic logic [W+1:0] model(input logic [N-1:0] bits);
        int ones;
        ones = $countones(bits);
`ifdef SC_DECODER_BIPOLAR_EN
        return (W+2)'(2 * ones - N);
`else
        return (W+2)'(ones);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start     = 1'b1;
        bit_valid = 1'($urandom_range(1));
        bit_in    = 1'($urandom_range(1));
        step();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || value !== last_value) begin
            n_fail++;
            $display("FAIL start_accept busy=%b done=%b value=%0d required busy=1 done=0 value=%0d",
                     busy, done, value, last_value);
        end
    endtask

    // Feeds one window in ACCUM; optional forced stall and a stray start at a sample index.
    task automatic feed_window(input logic [N-1:0] bits, input int stall_pct,
                               input int stall_at, input int stall_len, input int start_at);
        int n = 0;
        int guard = 0;
        int stalls = 0;
        logic [W+1:0] exp_v;
        exp_v = model(bits);
        while (n < N && guard < 1000) begin
            guard++;
            start = 1'b0;
            if (n == stall_at && stalls < stall_len) begin
                stalls++;
                bit_valid = 1'b0;
                bit_in    = 1'b1;
            end else if (int'($urandom_range(99)) < stall_pct) begin
                bit_valid = 1'b0;
                bit_in    = 1'($urandom_range(1));
            end else begin
                bit_valid = 1'b1;
                bit_in    = bits[n];
                start     = (n == start_at);
                n++;
            end
            step();
            if (n < N) begin
                n_cmp++;
                if (busy !== 1'b1 || done !== 1'b0 || value !== last_value) begin
                    n_fail++;
                    $display("FAIL window_hold n=%0d busy=%b done=%b value=%0d required busy=1 done=0 value=%0d",
                             n, busy, done, value, last_value);
                end
            end
        end
        start     = 1'b0;
        bit_valid = 1'b0;
        n_cmp++;
        if (guard >= 1000) begin
            n_fail++;
            $display("FAIL window_timeout samples=%0d required %0d", n, N);
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || value !== exp_v) begin
            n_fail++;
            $display("FAIL window_done done=%b busy=%b value=%0d required done=1 busy=0 value=%0d",
                     done, busy, value, exp_v);
        end
        last_value = exp_v;
    endtask

    // Cycle spent in DONE; start_next requests a back-to-back window.
    task automatic finish_done(input logic start_next);
        start     = start_next;
        bit_valid = 1'($urandom_range(1));
        bit_in    = 1'($urandom_range(1));
        step();
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || busy !== start_next || value !== last_value) begin
            n_fail++;
            $display("FAIL after_done done=%b busy=%b value=%0d required done=0 busy=%b value=%0d",
                     done, busy, value, start_next, last_value);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || value !== '0) begin
            n_fail++;
            $display("FAIL reset busy=%b done=%b value=%0d required 0 0 0", busy, done, value);
        end
        step();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_all_ones();
        do_start();
        feed_window(16'hFFFF, 0, -1, 0, -1);
        finish_done(1'b0);
    endtask

    task automatic test_patterns();
        logic [N-1:0] pats [3];
        pats[0] = 16'h5555;
        pats[1] = 16'h0000;
        pats[2] = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            do_start();
            feed_window(pats[i], 0, -1, 0, -1);
            finish_done(1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            do_start();
            feed_window(16'($urandom), 30, -1, 0, -1);
            finish_done(1'b0);
        end
    endtask

    task automatic test_stall();
        do_start();
        feed_window(16'h03FF, 0, 10, 5, -1);
        finish_done(1'b0);
    endtask

    task automatic test_start_ignored();
        do_start();
        feed_window(16'($urandom), 0, -1, 0, 6);
        finish_done(1'b0);
    endtask

    task automatic test_back_to_back();
        do_start();
        feed_window(16'($urandom), 20, -1, 0, -1);
        finish_done(1'b1);
        feed_window(16'($urandom), 20, -1, 0, -1);
        finish_done(1'b0);
    endtask

    task automatic test_mid_reset();
        do_start();
        for (int i = 0; i < 9; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            step();
        end
        bit_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || value !== '0) begin
            n_fail++;
            $display("FAIL mid_reset busy=%b done=%b value=%0d required 0 0 0", busy, done, value);
        end
        last_value = '0;
        step();
        rst = 1'b1;
        step();
        do_start();
        feed_window(16'hFFFF, 0, -1, 0, -1);
        finish_done(1'b0);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_patterns();
        test_stall();
        test_start_ignored();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
